// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit : PC owner, single-outstanding imem fetch, IF/ID stall/flush
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hold_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] addr_o,
  output logic [31:0] inst_o,
  output logic        valid_o,
  output logic        ifid_stall_o,
  output logic        ifid_flush_o
);

  localparam logic [1:0] S_REQ     = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_FULL    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_buf_addr;
  logic [31:0] r_buf_inst;
  logic        r_valid;
  logic [31:0] w_redirect_pc;

  assign w_redirect_pc = redirect_addr_i & 32'hFFFF_FFFC;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_valid    <= 1'b0;
      r_buf_addr <= 32'h0000_0000;
      r_buf_inst <= NOP_INST;
    end else if (redirect_i) begin
      // Redirect wins; a request already accepted must still be drained.
      r_pc    <= w_redirect_pc;
      r_valid <= 1'b0;
      case (r_state)
        S_REQ:     r_state <= imem_gnt_i    ? S_DISCARD : S_REQ;
        S_WAIT:    r_state <= imem_rvalid_i ? S_REQ     : S_DISCARD;
        S_FULL:    r_state <= S_REQ;
        S_DISCARD: r_state <= imem_rvalid_i ? S_REQ     : S_DISCARD;
        default:   r_state <= S_REQ;
      endcase
    end else begin
      case (r_state)
        S_REQ: begin
          if (imem_gnt_i) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            r_buf_inst <= imem_rdata_i;
            r_buf_addr <= r_pc;
            r_valid    <= 1'b1;
            r_pc       <= r_pc + 32'd4;
            r_state    <= S_FULL;
          end
        end
        S_FULL: begin
          if (!hold_i) begin
            r_valid <= 1'b0;
            r_state <= S_REQ;
          end
        end
        S_DISCARD: begin
          if (imem_rvalid_i) r_state <= S_REQ;
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  assign imem_req_o   = (r_state == S_REQ) & ~rst_i;
  assign imem_addr_o  = r_pc;
  assign addr_o       = r_buf_addr;
  assign inst_o       = r_buf_inst;
  assign valid_o      = r_valid;
  assign ifid_stall_o = hold_i & ~redirect_i;
  assign ifid_flush_o = redirect_i | (~r_valid & ~hold_i);

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit : table-driven fetch vectors, scoreboard, redirect/reset cases
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] addr_out;
  logic [31:0] inst_out;
  logic        valid_out;
  logic        ifid_stall;
  logic        ifid_flush;

  int tests = 0;
  int fails = 0;

  logic [63:0] sb[$];
  logic        outstanding = 1'b0;
  logic        prev_valid  = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    int          gnt_dly;
    int          rv_dly;
    int          hold_cyc;
  } vec_t;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .hold_i         (hold),
    .redirect_i     (redirect),
    .redirect_addr_i(redirect_addr),
    .imem_req_o     (imem_req),
    .imem_addr_o    (imem_addr),
    .imem_gnt_i     (imem_gnt),
    .imem_rvalid_i  (imem_rvalid),
    .imem_rdata_i   (imem_rdata),
    .addr_o         (addr_out),
    .inst_o         (inst_out),
    .valid_o        (valid_out),
    .ifid_stall_o   (ifid_stall),
    .ifid_flush_o   (ifid_flush)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 16) begin
      tick();
      n++;
    end
    check("req_timeout", {31'd0, imem_req}, 32'd1);
  endtask

  // Monitor: IF/ID controls, single outstanding request, scoreboard pops.
  always @(negedge clk) begin
    if (rst) begin
      outstanding = 1'b0;
      prev_valid  = 1'b0;
    end else begin
      check("flush", {31'd0, ifid_flush}, {31'd0, redirect | (~valid_out & ~hold)});
      check("stall", {31'd0, ifid_stall}, {31'd0, hold & ~redirect});
      check("single_outstanding", {31'd0, imem_req & outstanding}, 32'd0);
      if (imem_req && imem_gnt) outstanding = 1'b1;
      else if (imem_rvalid)     outstanding = 1'b0;
      if (valid_out && !prev_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_inst", inst_out, 32'hxxxx_xxxx);
        end else begin
          logic [63:0] e;
          e = sb.pop_front();
          check("sb_addr", addr_out, e[63:32]);
          check("sb_inst", inst_out, e[31:0]);
        end
      end
      prev_valid = valid_out;
    end
  end

  task automatic fetch_one(input vec_t v);
    wait_req();
    check("req_addr", imem_addr, v.addr);
    for (int i = 0; i < v.gnt_dly; i++) begin
      tick();
      check("req_held", {31'd0, imem_req}, 32'd1);
    end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check("req_in_wait", {31'd0, imem_req}, 32'd0);
    repeat (v.rv_dly) tick();
    imem_rvalid = 1'b1;
    imem_rdata  = v.inst;
    sb.push_back({v.addr, v.inst});
    hold = (v.hold_cyc > 0);
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    check("valid_full", {31'd0, valid_out}, 32'd1);
    for (int i = 0; i < v.hold_cyc; i++) begin
      check("hold_stall", {31'd0, ifid_stall}, 32'd1);
      check("hold_noreq", {31'd0, imem_req}, 32'd0);
      check("hold_valid", {31'd0, valid_out}, 32'd1);
      check("hold_addr", addr_out, v.addr);
      check("hold_inst", inst_out, v.inst);
      tick();
    end
    hold = 1'b0;
    tick();
    check("valid_drop", {31'd0, valid_out}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    vec_t v;

    vecs[0] = '{32'h0000_0000, 32'h0050_0093, 0, 0, 0};
    vecs[1] = '{32'h0000_0004, 32'h00a0_0113, 0, 0, 0};
    vecs[2] = '{32'h0000_0008, 32'h1234_5678, 2, 1, 0};
    vecs[3] = '{32'h0000_000C, 32'h0bad_f00d, 0, 3, 5};
    vecs[4] = '{32'h0000_0010, 32'hcafe_0013, 1, 0, 2};

    rst = 1'b1; hold = 1'b0; redirect = 1'b0; redirect_addr = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    repeat (3) tick();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_addr", addr_out, 32'h0);
    check("rst_inst", inst_out, 32'h0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) fetch_one(vecs[i]);

    // Redirect while WAIT; killed data arrives three cycles later.
    wait_req();
    check("a_addr", imem_addr, 32'h14);
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    redirect = 1'b1; redirect_addr = 32'h0000_0103;
    #1 check("a_flush", {31'd0, ifid_flush}, 32'd1);
    tick();
    redirect = 1'b0;
    check("a_disc0", {31'd0, imem_req}, 32'd0);
    tick();
    check("a_disc1", {31'd0, imem_req}, 32'd0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hdead_beef;
    tick();
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    check("a_req", {31'd0, imem_req}, 32'd1);
    check("a_newaddr", imem_addr, 32'h100);
    check("a_novalid", {31'd0, valid_out}, 32'd0);
    v = '{32'h0000_0100, 32'h0000_0013, 0, 0, 0};
    fetch_one(v);

    // Redirect coincident with rvalid and hold.
    wait_req();
    check("b_addr", imem_addr, 32'h104);
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hbad0_bad0;
    hold = 1'b1; redirect = 1'b1; redirect_addr = 32'h40;
    #1;
    check("b_flush", {31'd0, ifid_flush}, 32'd1);
    check("b_stall", {31'd0, ifid_stall}, 32'd0);
    tick();
    imem_rvalid = 1'b0; hold = 1'b0; redirect = 1'b0;
    check("b_valid", {31'd0, valid_out}, 32'd0);
    check("b_req", {31'd0, imem_req}, 32'd1);
    check("b_newaddr", imem_addr, 32'h40);
    v = '{32'h0000_0040, 32'h0010_0093, 0, 1, 0};
    fetch_one(v);

    // Back-to-back redirects while DISCARD.
    wait_req();
    check("c_addr", imem_addr, 32'h44);
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    redirect = 1'b1; redirect_addr = 32'h500; tick();
    redirect_addr = 32'h200; tick();
    check("c_disc0", {31'd0, imem_req}, 32'd0);
    redirect_addr = 32'h300; tick();
    redirect = 1'b0;
    check("c_disc1", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h5555_aaaa; tick();
    imem_rvalid = 1'b0;
    check("c_req", {31'd0, imem_req}, 32'd1);
    check("c_newaddr", imem_addr, 32'h300);
    v = '{32'h0000_0300, 32'h0020_0113, 0, 0, 0};
    fetch_one(v);

    // Redirect from REQ without gnt, low bits forced to zero, then wrap.
    wait_req();
    redirect = 1'b1; redirect_addr = 32'hFFFF_FFFF; tick();
    redirect = 1'b0;
    check("d_req", {31'd0, imem_req}, 32'd1);
    check("d_addr", imem_addr, 32'hFFFF_FFFC);
    imem_rvalid = 1'b1; imem_rdata = 32'h7777_7777; tick();
    imem_rvalid = 1'b0;
    check("d_stray_req", {31'd0, imem_req}, 32'd1);
    check("d_stray_addr", imem_addr, 32'hFFFF_FFFC);
    check("d_stray_valid", {31'd0, valid_out}, 32'd0);
    v = '{32'hFFFF_FFFC, 32'h0000_0073, 0, 0, 0};
    fetch_one(v);
    v = '{32'h0000_0000, 32'h0030_0193, 0, 0, 0};
    fetch_one(v);

    // Reset while a request is outstanding.
    wait_req();
    check("e_addr", imem_addr, 32'h4);
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    rst = 1'b1; tick();
    check("e_valid", {31'd0, valid_out}, 32'd0);
    check("e_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b0; tick();
    check("e_req_after", {31'd0, imem_req}, 32'd1);
    check("e_pc", imem_addr, 32'h0);
    tick();

    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
